// File: rtl/cpu_host_bridge.sv
// Host-side end of the CPU data port for an 8-bit pin budget.
// The receive path assembles two host bytes (low first) into a 16-bit CPU word
// and pulses cpu_data_read. The transmit path watches the CPU output word and
// sends each new value to the host as two bytes, low first, using an ack handshake.
//
// Ports:
//   clk, rst        - system clock; asynchronous active-low reset
//   host_byte_in    - byte from host, stable while host_strobe is high
//   host_strobe     - asynchronous host byte-valid level
//   host_byte_out   - byte to host
//   host_valid      - host_byte_out holds a valid byte
//   host_ack        - asynchronous host acknowledge level
//   cpu_word_in     - CPU data_out word
//   cpu_word_out    - CPU data_in word
//   cpu_data_read   - one-cycle pulse when cpu_word_out takes a new word
//   rx_busy         - low byte held, high byte pending
module cpu_host_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] RESET_WORD  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  host_byte_in,
    input  logic        host_strobe,
    output logic [7:0]  host_byte_out,
    output logic        host_valid,
    input  logic        host_ack,
    input  logic [15:0] cpu_word_in,
    output logic [15:0] cpu_word_out,
    output logic        cpu_data_read,
    output logic        rx_busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic {RX_LO, RX_HI} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_LO, TX_HI} tx_state_t;

    // Synchronisers and rising-edge detectors for the two host levels
    logic [SYNC_STAGES-1:0] strobe_sync;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   strobe_prev;
    logic                   ack_prev;
    logic                   strobe_evt_c;
    logic                   ack_evt_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strobe_sync <= '0;
            ack_sync    <= '0;
            strobe_prev <= 1'b0;
            ack_prev    <= 1'b0;
        end else begin
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], host_strobe};
            ack_sync    <= {ack_sync[SYNC_STAGES-2:0], host_ack};
            strobe_prev <= strobe_sync[SYNC_STAGES-1];
            ack_prev    <= ack_sync[SYNC_STAGES-1];
        end
    end

    assign strobe_evt_c = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
    assign ack_evt_c    = ack_sync[SYNC_STAGES-1] & ~ack_prev;

    // Receive FSM
    rx_state_t          rx_state, rx_state_nx;
    logic [BYTE_W-1:0]  lo_reg, lo_reg_nx;
    logic [WORD_W-1:0]  word_out_nx;
    logic               data_read_nx;
    logic               rx_busy_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state      <= RX_LO;
            lo_reg        <= '0;
            cpu_word_out  <= RESET_WORD;
            cpu_data_read <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            rx_state      <= rx_state_nx;
            lo_reg        <= lo_reg_nx;
            cpu_word_out  <= word_out_nx;
            cpu_data_read <= data_read_nx;
            rx_busy       <= rx_busy_nx;
        end
    end

    always_comb begin
        rx_state_nx  = rx_state;
        lo_reg_nx    = lo_reg;
        word_out_nx  = cpu_word_out;
        data_read_nx = 1'b0;
        rx_busy_nx   = rx_busy;
        case (rx_state)
            RX_LO: begin
                if (strobe_evt_c) begin
                    lo_reg_nx   = host_byte_in;
                    rx_state_nx = RX_HI;
                    rx_busy_nx  = 1'b1;
                end
            end
            RX_HI: begin
                if (strobe_evt_c) begin
                    word_out_nx  = {host_byte_in, lo_reg};
                    data_read_nx = 1'b1;
                    rx_state_nx  = RX_LO;
                    rx_busy_nx   = 1'b0;
                end
            end
        endcase
    end

    // Transmit FSM; shadow holds the word currently or last sent
    tx_state_t          tx_state, tx_state_nx;
    logic [WORD_W-1:0]  shadow, shadow_nx;
    logic [BYTE_W-1:0]  byte_out_nx;
    logic               valid_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state      <= TX_IDLE;
            shadow        <= RESET_WORD;
            host_byte_out <= '0;
            host_valid    <= 1'b0;
        end else begin
            tx_state      <= tx_state_nx;
            shadow        <= shadow_nx;
            host_byte_out <= byte_out_nx;
            host_valid    <= valid_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        shadow_nx   = shadow;
        byte_out_nx = host_byte_out;
        valid_nx    = host_valid;
        case (tx_state)
            TX_IDLE: begin
                if (cpu_word_in != shadow) begin
                    shadow_nx   = cpu_word_in;
                    byte_out_nx = cpu_word_in[BYTE_W-1:0];
                    valid_nx    = 1'b1;
                    tx_state_nx = TX_LO;
                end
            end
            TX_LO: begin
                if (ack_evt_c) begin
                    byte_out_nx = shadow[WORD_W-1:BYTE_W];
                    tx_state_nx = TX_HI;
                end
            end
            TX_HI: begin
                if (ack_evt_c) begin
                    valid_nx    = 1'b0;
                    tx_state_nx = TX_IDLE;
                end
            end
            default: begin
                tx_state_nx = TX_IDLE;
                valid_nx    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_host_bridge.sv
// Self-checking bench for cpu_host_bridge: directed scenarios plus randomized
// words, checked against a byte-level model of the host protocol.
module tb_cpu_host_bridge;

    logic        clk;
    logic        rst;
    logic [7:0]  host_byte_in;
    logic        host_strobe;
    logic [7:0]  host_byte_out;
    logic        host_valid;
    logic        host_ack;
    logic [15:0] cpu_word_in;
    logic [15:0] cpu_word_out;
    logic        cpu_data_read;
    logic        rx_busy;

    cpu_host_bridge #(.SYNC_STAGES(2), .RESET_WORD(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_byte_in  (host_byte_in),
        .host_strobe   (host_strobe),
        .host_byte_out (host_byte_out),
        .host_valid    (host_valid),
        .host_ack      (host_ack),
        .cpu_word_in   (cpu_word_in),
        .cpu_word_out  (cpu_word_out),
        .cpu_data_read (cpu_data_read),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host protocol model: received words expected in order, pending low byte
    logic [15:0] exp_q[$];
    bit          have_lo = 0;
    logic [7:0]  pend_lo = 8'h00;
    int          words_expected = 0;
    int          pulses_seen = 0;
    logic [15:0] tx_shadow = 16'h0000;
    logic [15:0] last_word = 16'h0000;
    bit          in_change_test = 0;
    bit          prev_read = 0;

    function automatic void model_byte(input logic [7:0] b);
        if (have_lo) begin
            exp_q.push_back({b, pend_lo});
            words_expected++;
            have_lo = 0;
        end else begin
            pend_lo = b;
            have_lo = 1;
        end
    endfunction

    // Every data_read pulse must carry the next expected word and last one cycle
    always @(negedge clk) begin
        if (rst && cpu_data_read) begin
            pulses_seen++;
            if (prev_read) check_eq("rx_pulse_width", 32'(1), 32'(0));
            if (exp_q.size() == 0) check_eq("rx_spurious_pulse", 32'(cpu_word_out), 32'hFFFF_FFFF);
            else check_eq("rx_word", 32'(cpu_word_out), 32'(exp_q.pop_front()));
        end
        prev_read = rst && cpu_data_read;
    end

    // Intermediate word 2222 must never reach the host
    always @(negedge clk) begin
        if (rst && in_change_test && host_valid && host_byte_out == 8'h22)
            check_eq("tx_dropped_byte", 32'(host_byte_out), 32'(8'h33));
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        model_byte(b);
        host_byte_in = b;
        host_strobe  = 1'b1;
        repeat (6) @(negedge clk);
        host_strobe = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rx_busy", 32'(rx_busy), 32'(have_lo));
    endtask

    task automatic tx_wait_valid(output logic [7:0] b);
        int n = 0;
        while (!host_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_valid_rise", 32'(host_valid), 32'(1));
        b = host_byte_out;
    endtask

    task automatic tx_ack_mid(output logic [7:0] b);
        host_ack = 1'b1;
        repeat (6) @(negedge clk);
        b = host_byte_out;
        check_eq("tx_valid_hold", 32'(host_valid), 32'(1));
        host_ack = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_ack_last();
        int n = 0;
        host_ack = 1'b1;
        @(negedge clk);
        while (host_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_valid_fall", 32'(host_valid), 32'(0));
        repeat (2) @(negedge clk);
        host_ack = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_word(input logic [15:0] w);
        logic [7:0] lo, hi;
        cpu_word_in = w;
        tx_wait_valid(lo);
        check_eq("tx_lo_byte", 32'(lo), 32'(w[7:0]));
        tx_ack_mid(hi);
        check_eq("tx_hi_byte", 32'(hi), 32'(w[15:8]));
        tx_ack_last();
        tx_shadow = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        logic [15:0] t;
        bit          seen;

        rst          = 1'b0;
        host_byte_in = 8'h00;
        host_strobe  = 1'b0;
        host_ack     = 1'b0;
        cpu_word_in  = 16'h0000;

        // Activity while reset is held must have no effect
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            host_byte_in = 8'($urandom);
            host_strobe  = 1'b1;
            host_ack     = 1'b1;
            repeat (5) @(negedge clk);
            host_strobe = 1'b0;
            host_ack    = 1'b0;
            repeat (2) @(negedge clk);
        end
        check_eq("rst_word_out", 32'(cpu_word_out), 32'(16'h0000));
        check_eq("rst_data_read", 32'(cpu_data_read), 32'(0));
        check_eq("rst_valid", 32'(host_valid), 32'(0));
        check_eq("rst_busy", 32'(rx_busy), 32'(0));
        check_eq("rst_byte_out", 32'(host_byte_out), 32'(0));
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("post_rst_word_out", 32'(cpu_word_out), 32'(16'h0000));
        check_eq("post_rst_valid", 32'(host_valid), 32'(0));
        check_eq("post_rst_pulses", 32'(pulses_seen), 32'(0));

        // Word receive
        send_byte(8'h34);
        send_byte(8'h12);
        check_eq("rx_word_hold", 32'(cpu_word_out), 32'(16'h1234));
        check_eq("rx_pulse_count", 32'(pulses_seen), 32'(1));

        // Partial word, then reset discards it
        send_byte(8'hAA);
        check_eq("rx_lone_lo_hold", 32'(cpu_word_out), 32'(16'h1234));
        @(negedge clk);
        rst     = 1'b0;
        have_lo = 0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_word_out", 32'(cpu_word_out), 32'(16'h0000));
        check_eq("mid_rst_busy", 32'(rx_busy), 32'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h78);
        send_byte(8'h56);
        check_eq("rx_after_rst_word", 32'(cpu_word_out), 32'(16'h5678));
        check_eq("rx_after_rst_pulses", 32'(pulses_seen), 32'(2));

        // Word transmit
        tx_word(16'hBEEF);
        repeat (5) @(negedge clk);
        check_eq("tx_idle_valid", 32'(host_valid), 32'(0));

        // Changes during a transfer: only the first and final values are sent
        in_change_test = 1;
        cpu_word_in = 16'h1111;
        tx_wait_valid(b);
        check_eq("chg_first_lo", 32'(b), 32'(8'h11));
        @(negedge clk);
        cpu_word_in = 16'h2222;
        repeat (2) @(negedge clk);
        cpu_word_in = 16'h3333;
        tx_ack_mid(b);
        check_eq("chg_first_hi", 32'(b), 32'(8'h11));
        tx_ack_last();
        tx_wait_valid(b);
        check_eq("chg_final_lo", 32'(b), 32'(8'h33));
        tx_ack_mid(b);
        check_eq("chg_final_hi", 32'(b), 32'(8'h33));
        tx_ack_last();
        tx_shadow = 16'h3333;
        repeat (10) @(negedge clk);
        check_eq("chg_no_more", 32'(host_valid), 32'(0));
        in_change_test = 0;

        // Simultaneous strobe and ack events: RX in high-byte phase, TX in low-byte phase
        send_byte(8'h9A);
        cpu_word_in = 16'hCDEF;
        tx_wait_valid(b);
        check_eq("sim_tx_lo", 32'(b), 32'(8'hEF));
        @(negedge clk);
        model_byte(8'hBC);
        host_byte_in = 8'hBC;
        host_strobe  = 1'b1;
        host_ack     = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (cpu_data_read) begin
                seen = 1;
                check_eq("sim_tx_hi_same_cycle", 32'(host_byte_out), 32'(8'hCD));
                check_eq("sim_rx_word", 32'(cpu_word_out), 32'(16'hBC9A));
            end
        end
        check_eq("sim_pulse_seen", 32'(seen), 32'(1));
        repeat (3) @(negedge clk);
        host_strobe = 1'b0;
        host_ack    = 1'b0;
        repeat (4) @(negedge clk);
        tx_ack_last();
        tx_shadow = 16'hCDEF;

        // Randomized traffic on both paths
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            check_eq("rnd_rx_word_hold", 32'(cpu_word_out), 32'(w));
            t = 16'($urandom);
            if (t == tx_shadow) t = t ^ 16'h0001;
            tx_word(t);
        end

        repeat (10) @(negedge clk);
        check_eq("final_pulse_count", 32'(pulses_seen), 32'(words_expected));
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
